// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the timing generator and the pixel generator.
package vga_timing_pkg;
  localparam int CLK_DIV   = 4;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W = 10;
  localparam int FC_W  = 8;

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } pos_t;

  // Inclusive range test on a raster coordinate.
  function automatic logic in_range(logic [CNT_W-1:0] x, int lo, int hi);
    return (int'(x) >= lo) && (int'(x) <= hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run enable in, pixel position / sync / frame markers out.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             en;
  logic             pclk_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             valid;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
  logic [FC_W-1:0]  frame_cnt;

  modport master (
    input  en,
    output pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate divider: tick qualifies the clk edge that advances the raster.
module pixel_tick_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic pclk_en
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick = en && (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      pclk_en <= 1'b0;
    end else begin
      pclk_en <= tick;
      if (tick)    div <= '0;
      else if (en) div <= div + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters plus registered video/sync/frame flags aligned to them.
module vga_timing_gen #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_timing_gen_if.master vga
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS  = H_VISIBLE + H_FRONT;
  localparam int H_SE  = H_SS + H_SYNC - 1;
  localparam int V_SS  = V_VISIBLE + V_FRONT;
  localparam int V_SE  = V_SS + V_SYNC - 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  logic            tick;
  pos_t            pos_q, pos_nx;
  logic            valid_q, hsync_q, vsync_q, line_q, frame_q;
  logic [FC_W-1:0] fc_q;
  logic            nx_origin;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (vga.en),
    .tick    (tick),
    .pclk_en (vga.pclk_en)
  );

  always_comb begin
    pos_nx = pos_q;
    if (pos_q.h == H_LAST) begin
      pos_nx.h = '0;
      pos_nx.v = (pos_q.v == V_LAST) ? '0 : pos_q.v + 1'b1;
    end else begin
      pos_nx.h = pos_q.h + 1'b1;
    end
  end

  assign nx_origin = (pos_nx.h == '0) && (pos_nx.v == '0);

  // Flags are computed from the next position so they land in the same cycle as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '{h: H_LAST, v: V_LAST};
      valid_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (tick) begin
        pos_q   <= pos_nx;
        valid_q <= (int'(pos_nx.h) < H_VISIBLE) && (int'(pos_nx.v) < V_VISIBLE);
        hsync_q <= !in_range(pos_nx.h, H_SS, H_SE);
        vsync_q <= !in_range(pos_nx.v, V_SS, V_SE);
        line_q  <= (pos_nx.h == '0);
        frame_q <= nx_origin;
        if (nx_origin) fc_q <= fc_q + 1'b1;
      end
    end
  end

  assign vga.h_cnt       = pos_q.h;
  assign vga.v_cnt       = pos_q.v;
  assign vga.valid       = valid_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
  assign vga.frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for line/pause/reset, a shrunken instance for frame-level behaviour.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rst_s;
  always #5 clk = ~clk;

  vga_timing_gen_if vb();
  vga_timing_gen_if vs();

  vga_timing_gen dut_b (.clk(clk), .rst_n(rst_n), .vga(vb.master));

  // 8x7 raster, 2 clk per pixel: hsync 5..6, vsync lines 4..5, visible 4x3.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (.clk(clk), .rst_n(rst_s), .vga(vs.master));

  int n_run  = 0;
  int n_fail = 0;
  int eh, ev, efc;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_b(string t, int h, int v, int val, int hs, int vsn, int pe, int ls, int fs, int fc);
    chk({t, "_h"}, 32'(vb.h_cnt), h);
    chk({t, "_v"}, 32'(vb.v_cnt), v);
    chk({t, "_valid"}, 32'(vb.valid), val);
    chk({t, "_hsync"}, 32'(vb.hsync), hs);
    chk({t, "_vsync"}, 32'(vb.vsync), vsn);
    chk({t, "_pclk_en"}, 32'(vb.pclk_en), pe);
    chk({t, "_line_start"}, 32'(vb.line_start), ls);
    chk({t, "_frame_start"}, 32'(vb.frame_start), fs);
    chk({t, "_frame_cnt"}, 32'(vb.frame_cnt), fc);
  endtask

  task automatic chk_s(string t, int h, int v, int val, int hs, int vsn, int pe, int ls, int fs, int fc);
    chk({t, "_h"}, 32'(vs.h_cnt), h);
    chk({t, "_v"}, 32'(vs.v_cnt), v);
    chk({t, "_valid"}, 32'(vs.valid), val);
    chk({t, "_hsync"}, 32'(vs.hsync), hs);
    chk({t, "_vsync"}, 32'(vs.vsync), vsn);
    chk({t, "_pclk_en"}, 32'(vs.pclk_en), pe);
    chk({t, "_line_start"}, 32'(vs.line_start), ls);
    chk({t, "_frame_start"}, 32'(vs.frame_start), fs);
    chk({t, "_frame_cnt"}, 32'(vs.frame_cnt), fc);
  endtask

  // Advance to the cycle after the next tick edge; n = clk edges consumed.
  task automatic tick_b(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!vb.pclk_en && n < 64);
    chk("b_tick_seen", 32'(vb.pclk_en), 1);
  endtask

  task automatic tick_s(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!vs.pclk_en && n < 64);
    chk("s_tick_seen", 32'(vs.pclk_en), 1);
  endtask

  // One pixel on the small raster against the reference position model.
  task automatic step_s(string t);
    int n;
    tick_s(n);
    chk({t, "_period"}, n, 2);
    if (eh == 7) begin
      eh = 0;
      ev = (ev == 6) ? 0 : ev + 1;
    end else eh++;
    if (eh == 0 && ev == 0) efc = (efc + 1) % 256;
    chk_s(t, eh, ev, int'(eh < 4 && ev < 3), int'(!(eh >= 5 && eh <= 6)),
          int'(!(ev >= 4 && ev <= 5)), 1, int'(eh == 0), int'(eh == 0 && ev == 0), efc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lcyc, h;
    rst_n = 1'b0; rst_s = 1'b0; vb.en = 1'b1; vs.en = 1'b1;
    #12;
    chk_b("b_reset", 799, 524, 0, 1, 1, 0, 0, 0, 0);
    chk_s("s_reset", 7, 6, 0, 1, 1, 0, 0, 0, 0);

    // Reset then run: first tick lands on (0,0) at the fourth edge.
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_b("b_pre_tick", 799, 524, 0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_b("b_first", 0, 0, 1, 1, 1, 1, 1, 1, 1);
    @(posedge clk); #1;
    chk_b("b_first_next", 0, 0, 1, 1, 1, 0, 0, 0, 1);

    // One full line: valid edge at 640, hsync low 656..751, line period 3200 clk.
    lcyc = 1;
    for (int i = 1; i <= 800; i++) begin
      tick_b(n);
      lcyc += n;
      h = i % 800;
      chk("b_line_h", 32'(vb.h_cnt), h);
      chk("b_line_v", 32'(vb.v_cnt), i / 800);
      chk("b_line_valid", 32'(vb.valid), int'(h < 640));
      chk("b_line_hsync", 32'(vb.hsync), int'(!(h >= 656 && h <= 751)));
      chk("b_line_vsync", 32'(vb.vsync), 1);
      chk("b_line_ls", 32'(vb.line_start), int'(h == 0));
      chk("b_line_fs", 32'(vb.frame_start), 0);
    end
    chk("b_line_period", lcyc, 3200);

    // en pause at h=300 of line 1, dropped one edge into the pixel.
    for (int i = 1; i <= 300; i++) tick_b(n);
    chk("b_pause_at", 32'(vb.h_cnt), 300);
    @(posedge clk); #1;
    @(negedge clk) vb.en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk); #1;
      chk_b("b_frozen", 300, 1, 1, 1, 1, 0, 0, 0, 1);
    end
    @(negedge clk) vb.en = 1'b1;
    tick_b(n);
    chk("b_resume_edges", n, 3);
    chk_b("b_resume", 301, 1, 1, 1, 1, 1, 0, 0, 1);

    // Async reset between edges at h=400.
    for (int i = 0; i < 99; i++) tick_b(n);
    chk("b_areset_at", 32'(vb.h_cnt), 400);
    #2 rst_n = 1'b0;
    #1 chk_b("b_areset", 799, 524, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_b("b_in_reset", 799, 524, 0, 1, 1, 0, 0, 0, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_b("b_rec_pre", 799, 524, 0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_b("b_rec_first", 0, 0, 1, 1, 1, 1, 1, 1, 1);

    // Small raster: first frame, wrap at (7,6)->(0,0), vsync window.
    @(negedge clk) rst_s = 1'b1;
    @(posedge clk); #1;
    chk_s("s_pre_tick", 7, 6, 0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_s("s_first", 0, 0, 1, 1, 1, 1, 1, 1, 1);
    eh = 0; ev = 0; efc = 1;
    for (int i = 0; i < 56; i++) step_s("s_frame0");
    chk_s("s_wrap", 0, 0, 1, 1, 1, 1, 1, 1, 2);

    // Mid-frame async reset at (2,3).
    while (!(eh == 2 && ev == 3)) step_s("s_frame1");
    #1 rst_s = 1'b0;
    #1 chk_s("s_areset", 7, 6, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_s("s_in_reset", 7, 6, 0, 1, 1, 0, 0, 0, 0);
    end
    @(negedge clk) rst_s = 1'b1;
    @(posedge clk); #1;
    chk_s("s_rec_pre", 7, 6, 0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_s("s_rec_first", 0, 0, 1, 1, 1, 1, 1, 1, 1);
    eh = 0; ev = 0; efc = 1;

    // 255 more frame starts: the 256th since reset wraps frame_cnt to 0.
    for (int i = 0; i < 255 * 56; i++) step_s("s_run");
    chk_s("s_fc_wrap", 0, 0, 1, 1, 1, 1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock: a pixel-rate enable, horizontal/vertical position counters, active-video flag and active-low sync pulses. It is the upstream driver of the pixel generator, which consumes `h_cnt`, `v_cnt`, `valid`, `hsync` and `vsync` combinationally to produce `vgaRed/vgaGreen/vgaBlue`. It also provides frame-level pulses and a frame counter so game logic can update scores between frames.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing in pixels. `H_TOTAL` = 800.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing in lines. `V_TOTAL` = 525.
- `clk  in  1`: system clock, 100 MHz. One clock domain only.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `en  in  1`: run enable. When low, the divider and all counters freeze.
- `pclk_en  out  1`: one-`clk` pulse, once per pixel period.
- `h_cnt  out  10`: horizontal position, 0..H_TOTAL-1.
- `v_cnt  out  10`: vertical position, 0..V_TOTAL-1.
- `valid  out  1`: high when `h_cnt` < H_VISIBLE and `v_cnt` < V_VISIBLE.
- `hsync  out  1`: active-low horizontal sync.
- `vsync  out  1`: active-low vertical sync.
- `line_start  out  1`: one-`clk` pulse when `h_cnt` becomes 0.
- `frame_start  out  1`: one-`clk` pulse when (`h_cnt`, `v_cnt`) becomes (0, 0).
- `frame_cnt  out  8`: number of frames begun since reset; wraps 255 -> 0.

## Operation
- **Divider.** `div` counts 0..CLK_DIV-1 while `en` = 1. The clock edge at which `div` = CLK_DIV-1 is a "tick".
  - On a tick, `div` goes to 0 and the pixel position advances.
  - With `en` = 0, `div` holds its value.
- **Horizontal counter.** On a tick, `h_cnt` increments. At H_TOTAL-1 it wraps to 0, and `v_cnt` increments at that same edge.
- **Vertical counter.** `v_cnt` wraps from V_TOTAL-1 to 0.
- **Derived outputs.** All are registered and computed from the *next* position, so they always match `h_cnt`/`v_cnt` in the same cycle.
  - `valid` = (h < 640) && (v < 480).
  - `hsync` = 0 iff 656 <= h <= 751.
  - `vsync` = 0 iff 490 <= v <= 491.
- **Pulses.** `pclk_en`, `line_start` and `frame_start` are high only in the cycle right after a tick edge, and only when their condition holds. `frame_cnt` increments at the same edge that raises `frame_start`.
- **Reset values.**
  - `div` = 0, `h_cnt` = 799, `v_cnt` = 524.
  - `valid` = 0, `hsync` = 1, `vsync` = 1.
  - `pclk_en` = 0, `line_start` = 0, `frame_start` = 0, `frame_cnt` = 0.
  - Consequence: the first tick after reset lands on (0, 0), which raises `frame_start` and sets `frame_cnt` = 1.
- **Reset mid-frame.** Asynchronously returns every register to its reset value. The partial frame is abandoned, and no extra `frame_start` is issued during reset.
- **`en` deasserted mid-line.** Outputs hold their last values, `valid` and sync levels included. Pulse outputs read 0 while frozen. Counting resumes from the held `div` with no skipped or duplicated pixel.

## Timing
- First tick occurs CLK_DIV `clk` edges after `rst_n` rises with `en` = 1. Position outputs change at that edge.
- Every position output is stable for exactly CLK_DIV cycles between ticks.
- Line = 800 ticks = 3200 `clk`. Frame = 525 lines = 1,680,000 `clk`.
- hsync low for 96 ticks. vsync low for 2 lines = 1600 ticks.
- Zero-latency alignment: `valid`, `hsync` and `vsync` never lag `h_cnt`/`v_cnt`.

## Structure
- **Shared package `vga_timing_pkg`** holds:
  - the timing constants;
  - the derived constants `H_TOTAL`, `V_TOTAL`, `H_SYNC_START`, `H_SYNC_END`, `V_SYNC_START`, `V_SYNC_END`;
  - the counter width (10).
- The pixel generator imports the same package for its visible-area limits.
- **One sub-module, `pixel_tick_gen`**: the divider. It takes `clk`, `rst_n` and `en`, and outputs `tick` (combinational edge qualifier) and `pclk_en` (registered).

## Test plan
- **Reset then run.** Release `rst_n` with `en` = 1.
  - At `clk` edge 4: `h_cnt` = 0, `v_cnt` = 0, `valid` = 1, `frame_start` = 1 for one cycle, `frame_cnt` = 1.
- **Line timing.** Over one line:
  - `valid` falls when `h_cnt` = 640.
  - `hsync` is low exactly for `h_cnt` 656..751.
  - `line_start` pulses every 3200 `clk`.
- **Frame wrap.**
  - At (799, 524) the next tick gives (0, 0), `frame_start` = 1 and `frame_cnt` +1.
  - `vsync` is low only for `v_cnt` 490..491.
  - 256 frames wrap `frame_cnt` to 0.
- **`en` pause.**
  - Drop `en` for 37 cycles at `h_cnt` = 300. All outputs hold, pulses stay 0.
  - On resume, the next `h_cnt` is 301, after the remaining divider count.
- **Async reset mid-frame.**
  - Assert `rst_n` at (400, 250) between clock edges. Outputs go to their reset values immediately, without waiting for a clock edge.
  - Recovery then matches the first scenario.
